spi_reg_bank: RTL and testbench

//  Register bank directly downstream of spi_slave_mode0. Consumes its addr_out/data_out/write_enable
//  and returns data_in for reads. Moves SPI writes from the SCLK domain into the system clk domain.

---
 rtl/spi_regbank_pkg.sv | 23 ++
 rtl/spi_reg_bank_pulse_sync.sv | 25 ++
 rtl/spi_reg_bank.sv | 155 +++++++++++++++
 tb/tb_spi_reg_bank.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regbank_pkg.sv
// Shared constants and types for the SPI register bank.
// Optional LOCK register is compiled in with SPI_REGBANK_LOCK_EN.
package spi_regbank_pkg;

  localparam logic [6:0] ADDR_LOCK   = 7'h7C;
  localparam logic [6:0] ADDR_STATUS = 7'h7E;
  localparam logic [6:0] ADDR_ID     = 7'h7F;

  // STATUS register bit positions; [3:0] is the wrapping write counter
  localparam int ST_ERR_ADDR = 7;
  localparam int ST_OVERRUN  = 6;
  localparam int ST_ERR_LOCK = 5;
  localparam int ST_LOCKED   = 4;

  localparam logic [7:0] LOCK_KEY = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_reg_bank_pulse_sync.sv
// Carries a write_enable pulse from the SCLK domain into clk as a 1-clk request:
// toggle on posedge spi_we, 3-FF synchroniser, XOR edge detect on the last two stages.
module spi_pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_we,
  output logic wr_req
);

  logic       tgl_q;
  logic [2:0] sync_q;

  always_ff @(posedge spi_we or negedge rst_n) begin
    if (!rst_n) tgl_q <= 1'b0;
    else        tgl_q <= ~tgl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], tgl_q};
  end

  assign wr_req = sync_q[2] ^ sync_q[1];

endmodule

// File: rtl/spi_reg_bank.sv
// Config register bank behind the SPI slave: commits SCLK-domain writes in clk,
// exposes STATUS/ID, and (with SPI_REGBANK_LOCK_EN) a LOCK register at 0x7C.
module spi_reg_bank
  import spi_regbank_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] RST_VAL  = 8'h00,
  parameter logic [7:0] ID_VAL   = 8'hC5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            spi_addr,
  input  logic [7:0]            spi_wdata,
  input  logic                  spi_we,
  output logic [7:0]            spi_rdata,
  output logic [NUM_REGS*8-1:0] cfg_regs,
  output logic                  reg_wr_strobe,
  output logic [6:0]            reg_wr_addr
);

  localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

  state_e state_q, state_d;
  logic   wr_req;
  logic   ovr_evt;

  logic [6:0] a_q;
  logic [7:0] d_q;
  logic       strobe_q;
  logic [6:0] wr_addr_q;
  logic       err_addr_q, overrun_q;
  logic [3:0] wc_q;
  logic [7:0] status;

  logic commit, in_range, cfg_we, lock_blk, status_w, bad_addr;
  logic locked_q, err_lock_q, lock_hit;

  logic [NUM_REGS-1:0][7:0] cfg_q;
  logic [NUM_REGS:0][7:0]   rd_chain;

  spi_pulse_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .spi_we (spi_we),
    .wr_req (wr_req)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_req) state_d = CAPTURE;
      CAPTURE: state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A request that lands while a write is in flight is dropped, not queued
  assign ovr_evt = wr_req && (state_q != IDLE);

  // ---------------- write decode ----------------
  assign commit   = (state_q == COMMIT);
  assign in_range = (a_q < NUM_REGS_A);
  assign cfg_we   = commit && in_range && !locked_q;
  assign lock_blk = commit && in_range && locked_q;
  assign status_w = commit && (a_q == ADDR_STATUS);
  assign bad_addr = commit && !in_range && (a_q != ADDR_STATUS) && !lock_hit;

`ifdef SPI_REGBANK_LOCK_EN
  assign lock_hit = (a_q == ADDR_LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q   <= 1'b0;
      err_lock_q <= 1'b0;
    end else begin
      if (commit && lock_hit) locked_q <= (d_q == LOCK_KEY);
      if (lock_blk)                              err_lock_q <= 1'b1;
      else if (status_w && d_q[ST_ERR_LOCK])     err_lock_q <= 1'b0;
    end
  end
`else
  assign lock_hit   = 1'b0;
  assign locked_q   = 1'b0;
  assign err_lock_q = 1'b0;
`endif

  // ---------------- datapath / status ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      d_q        <= '0;
      strobe_q   <= 1'b0;
      wr_addr_q  <= '0;
      err_addr_q <= 1'b0;
      overrun_q  <= 1'b0;
      wc_q       <= '0;
    end else begin
      // Strobe is registered so it lines up with the updated cfg_regs value
      strobe_q <= cfg_we;
      if (state_q == CAPTURE) begin
        a_q <= spi_addr;
        d_q <= spi_wdata;
      end
      if (cfg_we) begin
        wr_addr_q <= a_q;
        wc_q      <= wc_q + 4'd1;
      end
      if (bad_addr)                          err_addr_q <= 1'b1;
      else if (status_w && d_q[ST_ERR_ADDR]) err_addr_q <= 1'b0;
      // A fresh overrun wins over a simultaneous W1C clear
      if (ovr_evt)                           overrun_q <= 1'b1;
      else if (status_w && d_q[ST_OVERRUN])  overrun_q <= 1'b0;
    end
  end

  assign status = {err_addr_q, overrun_q, err_lock_q, locked_q, wc_q};

  // ---------------- config registers + read chain ----------------
  assign rd_chain[0] = '0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [7:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_q <= RST_VAL;
      else if (cfg_we && (a_q == 7'(g)))   r_q <= d_q;
    end

    assign cfg_q[g]      = r_q;
    assign rd_chain[g+1] = rd_chain[g] | ((spi_addr == 7'(g)) ? r_q : 8'h00);
  end

  assign cfg_regs      = cfg_q;
  assign reg_wr_strobe = strobe_q;
  assign reg_wr_addr   = wr_addr_q;

  // Registers are quasi-static while the SPI master reads, so no handshake here
  always_comb begin
    spi_rdata = 8'h00;
    if (spi_addr < NUM_REGS_A)         spi_rdata = rd_chain[NUM_REGS];
    else if (spi_addr == ADDR_STATUS)  spi_rdata = status;
    else if (spi_addr == ADDR_ID)      spi_rdata = ID_VAL;
`ifdef SPI_REGBANK_LOCK_EN
    if (spi_addr == ADDR_LOCK)         spi_rdata = {7'b0, locked_q};
`endif
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed vector table, multi-cycle corner
// sequences, and random writes checked against a rule-level register model.
module tb_spi_reg_bank;

  localparam int NR = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      spi_addr = '0;
  logic [7:0]      spi_wdata = '0;
  logic            spi_we = 1'b0;
  logic [7:0]      spi_rdata;
  logic [NR*8-1:0] cfg_regs;
  logic            reg_wr_strobe;
  logic [6:0]      reg_wr_addr;

  always #5 clk = ~clk;

  spi_reg_bank #(.NUM_REGS(NR), .RST_VAL(8'h00), .ID_VAL(8'hC5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi_addr      (spi_addr),
    .spi_wdata     (spi_wdata),
    .spi_we        (spi_we),
    .spi_rdata     (spi_rdata),
    .cfg_regs      (cfg_regs),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_addr   (reg_wr_addr)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chkw(input string nm, input logic [NR*8-1:0] act, input logic [NR*8-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // ---------------- reference model (register rules, not RTL structure) ----------------
  logic [7:0] m_cfg[$];
  bit         m_ea, m_ov, m_el, m_lk;
  int         m_wc;
  logic [6:0] m_wa;

  function void m_reset();
    m_cfg.delete();
    for (int i = 0; i < NR; i++) m_cfg.push_back(8'h00);
    m_ea = 0; m_ov = 0; m_el = 0; m_lk = 0; m_wc = 0; m_wa = '0;
  endfunction

  // Applies one committed write; returns whether a strobe is expected
  function bit m_write(input logic [6:0] a, input logic [7:0] d);
    int ai;
    ai = int'(a);
    if (ai < NR) begin
`ifdef SPI_REGBANK_LOCK_EN
      if (m_lk) begin m_el = 1; return 1'b0; end
`endif
      m_cfg[ai] = d; m_wa = a; m_wc = (m_wc + 1) % 16;
      return 1'b1;
    end
    if (ai == 'h7E) begin
      if (d[7]) m_ea = 0;
      if (d[6]) m_ov = 0;
      if (d[5]) m_el = 0;
      return 1'b0;
    end
`ifdef SPI_REGBANK_LOCK_EN
    if (ai == 'h7C) begin m_lk = (d == 8'hA5); return 1'b0; end
`endif
    m_ea = 1;
    return 1'b0;
  endfunction

  function logic [7:0] m_status();
    return {m_ea, m_ov, m_el, m_lk, m_wc[3:0]};
  endfunction

  function logic [7:0] m_read(input logic [6:0] a);
    int ai;
    ai = int'(a);
    if (ai < NR)     return m_cfg[ai];
    if (ai == 'h7E)  return m_status();
    if (ai == 'h7F)  return 8'hC5;
`ifdef SPI_REGBANK_LOCK_EN
    if (ai == 'h7C)  return {7'b0, m_lk};
`endif
    return 8'h00;
  endfunction

  function logic [NR*8-1:0] m_flat();
    logic [NR*8-1:0] f;
    f = '0;
    for (int i = NR - 1; i >= 0; i--) f = {f[NR*8-9:0], m_cfg[i]};
    return f;
  endfunction

  // ---------------- drivers ----------------
  task automatic rd(input logic [6:0] a, output logic [7:0] v);
    @(negedge clk);
    spi_addr = a;
    #1 v = spi_rdata;
  endtask

  // One SPI frame's write_enable pulse, then a bounded window counting strobes
  task automatic spi_write(input logic [6:0] a, input logic [7:0] d, output int ns, output int lat);
    @(negedge clk);
    spi_addr = a; spi_wdata = d; spi_we = 1'b1;
    ns = 0; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) spi_we = 1'b0;
      if (reg_wr_strobe) begin
        ns++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  task automatic post(input string nm, input bit e, input int ns, input int lat);
    logic [7:0] v;
    chk8({nm, " strobes"}, 8'(ns), e ? 8'd1 : 8'd0);
    if (e) chk8({nm, " latency in 5..6"}, (lat >= 5 && lat <= 6) ? 8'd1 : 8'd0, 8'd1);
    chk8({nm, " wr_addr"}, {1'b0, reg_wr_addr}, {1'b0, m_wa});
    rd(7'h7E, v);
    chk8({nm, " status"}, v, m_status());
    chkw({nm, " cfg"}, cfg_regs, m_flat());
  endtask

  task automatic do_write(input string nm, input logic [6:0] a, input logic [7:0] d);
    bit e;
    int ns, lat;
    e = m_write(a, d);
    spi_write(a, d, ns, lat);
    post(nm, e, ns, lat);
  endtask

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    int         stb;
    logic [7:0] st;
    logic [7:0] rdv;
    logic [6:0] wa;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] v, wc0;
    logic [6:0] a, ra;
    logic [7:0] d;
    bit e;
    int ns, lat, r;

    tbl[0] = '{7'h05, 8'hA3, 1, 8'h01, 8'hA3, 7'h05};
    tbl[1] = '{7'h40, 8'h5A, 0, 8'h81, 8'h00, 7'h05};
    tbl[2] = '{7'h7E, 8'h80, 0, 8'h01, 8'h01, 7'h05};
    tbl[3] = '{7'h0F, 8'h5A, 1, 8'h02, 8'h5A, 7'h0F};
    tbl[4] = '{7'h10, 8'h77, 0, 8'h82, 8'h00, 7'h0F};
    tbl[5] = '{7'h7E, 8'hE0, 0, 8'h02, 8'h02, 7'h0F};
    tbl[6] = '{7'h7F, 8'h11, 0, 8'h82, 8'hC5, 7'h0F};
    tbl[7] = '{7'h7E, 8'h80, 0, 8'h02, 8'h02, 7'h0F};
    tbl[8] = '{7'h00, 8'hFF, 1, 8'h03, 8'hFF, 7'h00};

    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chkw("reset cfg", cfg_regs, '0);
    chk8("reset strobe", {7'b0, reg_wr_strobe}, 8'h00);
    chk8("reset wr_addr", {1'b0, reg_wr_addr}, 8'h00);
    rd(7'h7F, v); chk8("reset id", v, 8'hC5);
    rd(7'h7E, v); chk8("reset status", v, 8'h00);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      e = m_write(tbl[i].a, tbl[i].d);
      spi_write(tbl[i].a, tbl[i].d, ns, lat);
      chk8($sformatf("vec%0d strobes", i), 8'(ns), 8'(tbl[i].stb));
      if (tbl[i].stb == 1)
        chk8($sformatf("vec%0d latency in 5..6", i), (lat >= 5 && lat <= 6) ? 8'd1 : 8'd0, 8'd1);
      chk8($sformatf("vec%0d wr_addr", i), {1'b0, reg_wr_addr}, {1'b0, tbl[i].wa});
      rd(7'h7E, v); chk8($sformatf("vec%0d status", i), v, tbl[i].st);
      rd(tbl[i].a, v); chk8($sformatf("vec%0d readback", i), v, tbl[i].rdv);
      chkw($sformatf("vec%0d cfg", i), cfg_regs, m_flat());
    end

    // 16 legal writes bring wr_count back to where it started
    wc0 = m_status() & 8'h0F;
    for (int i = 0; i < 16; i++)
      do_write($sformatf("wrap%0d", i), 7'($urandom_range(0, NR - 1)), 8'($urandom));
    rd(7'h7E, v); chk8("wr_count wrap", v & 8'h0F, wc0);

    // Second spi_we pulse two clocks after the first: only the first commits
    @(negedge clk);
    spi_addr = 7'h03; spi_wdata = 8'h3C; spi_we = 1'b1;
    @(negedge clk); spi_we = 1'b0;
    @(negedge clk); spi_we = 1'b1;
    ns = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) spi_we = 1'b0;
      if (reg_wr_strobe) ns++;
    end
    e = m_write(7'h03, 8'h3C);
    m_ov = 1;
    chk8("overrun strobes", 8'(ns), 8'd1);
    rd(7'h7E, v); chk8("overrun flag", {7'b0, v[6]}, 8'h01);
    chk8("overrun status", v, m_status());
    chkw("overrun cfg", cfg_regs, m_flat());

    // Reset between spi_we and strobe: nothing commits
    @(negedge clk);
    spi_addr = 7'h07; spi_wdata = 8'h99; spi_we = 1'b1;
    @(negedge clk); spi_we = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    ns = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (reg_wr_strobe) ns++;
    end
    m_reset();
    chk8("midreset strobes", 8'(ns), 8'd0);
    chkw("midreset cfg", cfg_regs, '0);
    chk8("midreset wr_addr", {1'b0, reg_wr_addr}, 8'h00);
    rd(7'h7E, v); chk8("midreset status", v, 8'h00);
    do_write("post-reset write", 7'h07, 8'h99);

`ifdef SPI_REGBANK_LOCK_EN
    do_write("lock set", 7'h7C, 8'hA5);
    rd(7'h7C, v); chk8("lock read", v, 8'h01);
    do_write("locked write", 7'h03, 8'h11);
    rd(7'h7E, v); chk8("lock flags", {6'b0, v[5:4]}, 8'h03);
    rd(7'h03, v); chk8("locked cfg3", v, 8'h00);
    do_write("unlock", 7'h7C, 8'h00);
    do_write("unlocked write", 7'h03, 8'h11);
    rd(7'h03, v); chk8("unlocked cfg3", v, 8'h11);
`else
    do_write("clear flags", 7'h7E, 8'hE0);
    do_write("lock addr write", 7'h7C, 8'h5A);
    rd(7'h7E, v);
    chk8("lock addr err", {7'b0, v[7]}, 8'h01);
    chk8("status[5:4] zero", {6'b0, v[5:4]}, 8'h00);
    rd(7'h7C, v); chk8("lock addr read", v, 8'h00);
`endif

    // Random writes against the model
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      d = 8'($urandom);
      if (r <= 5)      a = 7'($urandom_range(0, NR - 1));
      else if (r == 6) a = 7'h7E;
      else if (r == 7) begin a = 7'h7C; if ($urandom_range(0, 1) == 1) d = 8'hA5; end
      else             a = 7'($urandom);
      do_write($sformatf("rnd%0d a=%h", i, a), a, d);
      ra = (i % 2 == 0) ? 7'($urandom_range(0, NR + 2)) : 7'($urandom);
      rd(ra, v);
      chk8($sformatf("rnd%0d read %h", i, ra), v, m_read(ra));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
